// File: rtl/cond_logic.sv
// cond_logic: ARM condition check on registered NZCV flags, gated PCSrc/RegWrite/MemWrite, flag register and saturating exec/skip counters
module cond_logic #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InstrValid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SkipCount
);
   logic n, z, c, v, fire;
   assign {n, z, c, v} = Flags;
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = z;
         4'b0001: CondEx = !z;
         4'b0010: CondEx = c;
         4'b0011: CondEx = !c;
         4'b0100: CondEx = n;
         4'b0101: CondEx = !n;
         4'b0110: CondEx = v;
         4'b0111: CondEx = !v;
         4'b1000: CondEx = c & !z;
         4'b1001: CondEx = !c | z;
         4'b1010: CondEx = n == v;
         4'b1011: CondEx = n != v;
         4'b1100: CondEx = !z & (n == v);
         4'b1101: CondEx = z | (n != v);
         4'b1110: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end
   assign fire     = reset & InstrValid & CondEx;
   assign PCSrc    = PCS & fire;
   assign RegWrite = RegW & fire;
   assign MemWrite = MemW & fire;
   always_ff @(posedge clk) begin
      if (!reset) begin
         Flags     <= '0;
         ExecCount <= '0;
         SkipCount <= '0;
      end else if (InstrValid) begin
         if (CondEx) begin
            if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
            ExecCount <= (&ExecCount) ? ExecCount : ExecCount + 1'b1;
         end else begin
            SkipCount <= (&SkipCount) ? SkipCount : SkipCount + 1'b1;
         end
      end
   end
endmodule
